// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse, lock qualification and ordered release of downstream reset domains.
// Runs on the PLL reference clock so it keeps sequencing while the PLL is unlocked.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES     = 8,
    parameter int LOCK_TIMEOUT       = 1000000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int NUM_STAGES         = 2
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  clr_count,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [2:0]            state_o,
    output logic [7:0]            loss_count,
    output logic [7:0]            timeout_count
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
    localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW     = $clog2(MAXC + 1);

    localparam logic [TW-1:0] T_ZERO    = '0;
    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [TW-1:0] C_PLL     = TW'(PLL_RST_CYCLES);
    localparam logic [TW-1:0] C_TO_M1   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] C_STB_M1  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] C_SD_M1   = TW'(STAGE_DELAY - 1);
    localparam logic [NUM_STAGES-1:0] ALL1 = '1;
    localparam logic [7:0]    CNT_MAX   = 8'hFF;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic                  r_pll_rst;
    logic [NUM_STAGES-1:0] r_rst_out;
    logic                  r_ready;
    logic                  r_sync1;
    logic                  r_locked_s;
    logic [7:0]            r_loss_count;
    logic [7:0]            r_timeout_count;

    state_t                w_state_nxt;
    logic [TW-1:0]         w_timer_nxt;
    logic                  w_pll_rst_nxt;
    logic [NUM_STAGES-1:0] w_rst_out_nxt;
    logic                  w_ready_nxt;
    logic                  w_loss_inc;
    logic                  w_to_inc;

    // The PLL_RST timer starts at 1 on entry so the pulse lasts PLL_RST_CYCLES clocks;
    // from reset it starts at 0, which adds the first released edge to the pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_pll_rst_nxt = r_pll_rst;
        w_rst_out_nxt = r_rst_out;
        w_ready_nxt   = r_ready;
        w_loss_inc    = 1'b0;
        w_to_inc      = 1'b0;
        case (r_state)
            S_PLL_RST: begin
                w_pll_rst_nxt = 1'b1;
                w_rst_out_nxt = ALL1;
                w_ready_nxt   = 1'b0;
                if (r_timer >= C_PLL) begin
                    w_state_nxt   = S_WAIT_LOCK;
                    w_timer_nxt   = T_ZERO;
                    w_pll_rst_nxt = 1'b0;
                end else begin
                    w_timer_nxt = r_timer + T_ONE;
                end
            end
            S_WAIT_LOCK: begin
                w_pll_rst_nxt = 1'b0;
                if (r_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_timer_nxt = T_ZERO;
                end else if (r_timer >= C_TO_M1) begin
                    w_state_nxt   = S_PLL_RST;
                    w_timer_nxt   = T_ONE;
                    w_pll_rst_nxt = 1'b1;
                    w_to_inc      = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + T_ONE;
                end
            end
            S_STABLE: begin
                if (!r_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_timer_nxt = T_ZERO;
                end else if (r_timer >= C_STB_M1) begin
                    w_timer_nxt   = T_ZERO;
                    w_rst_out_nxt = ALL1 << 1;
                    if (NUM_STAGES == 1) begin
                        w_state_nxt = S_RUN;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RELEASE;
                    end
                end else begin
                    w_timer_nxt = r_timer + T_ONE;
                end
            end
            S_RELEASE, S_RUN: begin
                if (!r_locked_s) begin
                    w_state_nxt   = S_PLL_RST;
                    w_timer_nxt   = T_ONE;
                    w_pll_rst_nxt = 1'b1;
                    w_rst_out_nxt = ALL1;
                    w_ready_nxt   = 1'b0;
                    w_loss_inc    = 1'b1;
                end else if (r_state == S_RELEASE) begin
                    if (r_timer >= C_SD_M1) begin
                        // Shifting left drops the lowest still-asserted stage.
                        w_timer_nxt   = T_ZERO;
                        w_rst_out_nxt = r_rst_out << 1;
                        if ((r_rst_out << 1) == '0) begin
                            w_state_nxt = S_RUN;
                            w_ready_nxt = 1'b1;
                        end
                    end else begin
                        w_timer_nxt = r_timer + T_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt   = S_PLL_RST;
                w_timer_nxt   = T_ONE;
                w_pll_rst_nxt = 1'b1;
                w_rst_out_nxt = ALL1;
                w_ready_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state    <= S_PLL_RST;
            r_timer    <= T_ZERO;
            r_pll_rst  <= 1'b1;
            r_rst_out  <= ALL1;
            r_ready    <= 1'b0;
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_pll_rst  <= w_pll_rst_nxt;
            r_rst_out  <= w_rst_out_nxt;
            r_ready    <= w_ready_nxt;
            r_sync1    <= pll_locked;
            r_locked_s <= r_sync1;
        end
    end

    // Clear beats a simultaneous increment; both counters stick at 255.
    always_ff @(posedge refclk) begin
        if (rst || clr_count) begin
            r_loss_count    <= 8'd0;
            r_timeout_count <= 8'd0;
        end else begin
            if (w_loss_inc && (r_loss_count != CNT_MAX)) begin
                r_loss_count <= r_loss_count + 8'd1;
            end
            if (w_to_inc && (r_timeout_count != CNT_MAX)) begin
                r_timeout_count <= r_timeout_count + 8'd1;
            end
        end
    end

    assign pll_rst       = r_pll_rst;
    assign rst_out       = r_rst_out;
    assign ready         = r_ready;
    assign state_o       = r_state;
    assign loss_count    = r_loss_count;
    assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: vector table for bring-up, hand sequences for
// timeout, glitch, loss, reset-in-release and counter saturation/clear.
module tb_pll_reset_sequencer;

    localparam int PRC = 2;
    localparam int LTO = 20;
    localparam int LSC = 4;
    localparam int SD  = 3;
    localparam int NS  = 2;

    logic          refclk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          clr_count;
    logic          pll_rst;
    logic [NS-1:0] rst_out;
    logic          ready;
    logic [2:0]    state_o;
    logic [7:0]    loss_count;
    logic [7:0]    timeout_count;

    int total = 0;
    int bad   = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES    (PRC),
        .LOCK_TIMEOUT      (LTO),
        .LOCK_STABLE_CYCLES(LSC),
        .STAGE_DELAY       (SD),
        .NUM_STAGES        (NS)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .clr_count    (clr_count),
        .pll_rst      (pll_rst),
        .rst_out      (rst_out),
        .ready        (ready),
        .state_o      (state_o),
        .loss_count   (loss_count),
        .timeout_count(timeout_count)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic          locked;
        logic          exp_pll;
        logic [NS-1:0] exp_ro;
        logic          exp_rdy;
        logic [2:0]    exp_st;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic chk_out(input string name, input logic p, input logic [NS-1:0] ro,
                           input logic rdy, input logic [2:0] st);
        chk({name, ".pll_rst"}, {31'd0, pll_rst}, {31'd0, p});
        chk({name, ".rst_out"}, {30'd0, rst_out}, {30'd0, ro});
        chk({name, ".ready"},   {31'd0, ready},   {31'd0, rdy});
        chk({name, ".state"},   {29'd0, state_o}, {29'd0, st});
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        clr_count  = 1'b0;
        tick(2);
        chk_out("reset", 1'b1, 2'b11, 1'b0, 3'd0);
        chk("reset.loss", {24'd0, loss_count}, 32'd0);
        chk("reset.tmo", {24'd0, timeout_count}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (state_o !== s && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, {29'd0, state_o}, {29'd0, s});
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        clr_count  = 1'b0;

        // Nominal bring-up: entry i is applied before edge i+1 after reset release.
        vt[0]  = '{1'b0, 1'b1, 2'b11, 1'b0, 3'd0};
        vt[1]  = '{1'b0, 1'b1, 2'b11, 1'b0, 3'd0};
        vt[2]  = '{1'b0, 1'b0, 2'b11, 1'b0, 3'd1};
        vt[3]  = '{1'b0, 1'b0, 2'b11, 1'b0, 3'd1};
        vt[4]  = '{1'b0, 1'b0, 2'b11, 1'b0, 3'd1};
        vt[5]  = '{1'b1, 1'b0, 2'b11, 1'b0, 3'd1};
        vt[6]  = '{1'b1, 1'b0, 2'b11, 1'b0, 3'd1};
        vt[7]  = '{1'b1, 1'b0, 2'b11, 1'b0, 3'd2};
        vt[8]  = '{1'b1, 1'b0, 2'b11, 1'b0, 3'd2};
        vt[9]  = '{1'b1, 1'b0, 2'b11, 1'b0, 3'd2};
        vt[10] = '{1'b1, 1'b0, 2'b11, 1'b0, 3'd2};
        vt[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 3'd3};
        vt[12] = '{1'b1, 1'b0, 2'b10, 1'b0, 3'd3};
        vt[13] = '{1'b1, 1'b0, 2'b10, 1'b0, 3'd3};
        vt[14] = '{1'b1, 1'b0, 2'b00, 1'b1, 3'd4};
        vt[15] = '{1'b1, 1'b0, 2'b00, 1'b1, 3'd4};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            pll_locked = vt[i].locked;
            tick(1);
            chk_out($sformatf("bringup[%0d]", i), vt[i].exp_pll, vt[i].exp_ro,
                    vt[i].exp_rdy, vt[i].exp_st);
        end

        // Loss in RUN (continues from edge 16).
        pll_locked = 1'b0;
        tick(2);
        chk_out("run_loss.e18", 1'b0, 2'b00, 1'b1, 3'd4);
        tick(1);
        chk_out("run_loss.e19", 1'b1, 2'b11, 1'b0, 3'd0);
        chk("run_loss.count", {24'd0, loss_count}, 32'd1);
        pll_locked = 1'b1;
        tick(1);
        chk_out("run_loss.e20", 1'b1, 2'b11, 1'b0, 3'd0);
        tick(1);
        chk_out("run_loss.e21", 1'b0, 2'b11, 1'b0, 3'd1);
        tick(1);
        chk("run_loss.e22", {29'd0, state_o}, 32'd2);
        tick(4);
        chk_out("run_loss.e26", 1'b0, 2'b10, 1'b0, 3'd3);
        tick(3);
        chk_out("run_loss.e29", 1'b0, 2'b00, 1'b1, 3'd4);
        chk("run_loss.count2", {24'd0, loss_count}, 32'd1);

        // Lock timeout: 22-clock re-pulse period.
        do_reset();
        tick(22);
        chk_out("tmo.e22", 1'b0, 2'b11, 1'b0, 3'd1);
        chk("tmo.e22.cnt", {24'd0, timeout_count}, 32'd0);
        tick(1);
        chk_out("tmo.e23", 1'b1, 2'b11, 1'b0, 3'd0);
        chk("tmo.e23.cnt", {24'd0, timeout_count}, 32'd1);
        tick(1);
        chk("tmo.e24", {31'd0, pll_rst}, 32'd1);
        tick(1);
        chk_out("tmo.e25", 1'b0, 2'b11, 1'b0, 3'd1);
        tick(19);
        chk("tmo.e44", {31'd0, pll_rst}, 32'd0);
        tick(1);
        chk("tmo.e45", {31'd0, pll_rst}, 32'd1);
        chk("tmo.e45.cnt", {24'd0, timeout_count}, 32'd2);
        tick(22);
        chk("tmo.e67", {31'd0, pll_rst}, 32'd1);
        chk("tmo.e67.cnt", {24'd0, timeout_count}, 32'd3);

        // One-clock lock glitch during the stability count.
        do_reset();
        pll_locked = 1'b1;
        tick(4);
        chk("glitch.e4", {29'd0, state_o}, 32'd2);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        chk("glitch.e6", {29'd0, state_o}, 32'd2);
        tick(1);
        chk_out("glitch.e7", 1'b0, 2'b11, 1'b0, 3'd1);
        tick(1);
        chk("glitch.e8", {29'd0, state_o}, 32'd2);
        tick(3);
        chk_out("glitch.e11", 1'b0, 2'b11, 1'b0, 3'd2);
        chk("glitch.loss", {24'd0, loss_count}, 32'd0);
        chk("glitch.tmo", {24'd0, timeout_count}, 32'd0);
        tick(1);
        chk_out("glitch.e12", 1'b0, 2'b10, 1'b0, 3'd3);

        // Loss mid-RELEASE, arriving on the edge that would release stage 1.
        do_reset();
        pll_locked = 1'b1;
        tick(8);
        chk_out("rel_loss.e8", 1'b0, 2'b10, 1'b0, 3'd3);
        pll_locked = 1'b0;
        tick(2);
        chk_out("rel_loss.e10", 1'b0, 2'b10, 1'b0, 3'd3);
        tick(1);
        chk_out("rel_loss.e11", 1'b1, 2'b11, 1'b0, 3'd0);
        chk("rel_loss.count", {24'd0, loss_count}, 32'd1);

        // rst asserted in RELEASE.
        pll_locked = 1'b1;
        tick(7);
        chk_out("rel_rst.e18", 1'b0, 2'b10, 1'b0, 3'd3);
        rst = 1'b1;
        tick(1);
        chk_out("rel_rst.e19", 1'b1, 2'b11, 1'b0, 3'd0);
        chk("rel_rst.loss", {24'd0, loss_count}, 32'd0);
        rst = 1'b0;
        pll_locked = 1'b0;

        // Timeout counter saturation, then clear coinciding with a loss event.
        do_reset();
        tick(5589);
        chk("sat.254", {24'd0, timeout_count}, 32'd254);
        tick(111);
        chk("sat.255", {24'd0, timeout_count}, 32'd255);
        pll_locked = 1'b1;
        wait_state(3'd4, 60, "sat.reach_run");
        pll_locked = 1'b0;
        tick(2);
        chk("clr.pre_state", {29'd0, state_o}, 32'd4);
        chk("clr.pre_tmo", {24'd0, timeout_count}, 32'd255);
        clr_count = 1'b1;
        tick(1);
        clr_count = 1'b0;
        chk_out("clr.edge", 1'b1, 2'b11, 1'b0, 3'd0);
        chk("clr.loss", {24'd0, loss_count}, 32'd0);
        chk("clr.tmo", {24'd0, timeout_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Consumes the `locked` indication of the system PLL and generates the ordered reset release for downstream logic. It runs on the PLL reference clock, so it keeps working while the PLL is unlocked. It pulses the PLL reset, waits for a stable lock, then releases NUM_STAGES reset domains one by one. It re-arms on loss of lock or on lock timeout and counts both events for debug.

## Interface

Parameters:
- `PLL_RST_CYCLES`, 8: width of the PLL reset pulse, in clocks.
- `LOCK_TIMEOUT`, 1000000: clocks to wait for lock before re-pulsing the PLL reset (20 ms at 50 MHz).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked clocks required before any release.
- `STAGE_DELAY`, 16: clocks between successive stage releases.
- `NUM_STAGES`, 2: number of sequenced reset outputs (1..8).

Ports:
- `refclk` in 1: 50 MHz reference clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL locked, asynchronous to `refclk`.
- `clr_count` in 1: synchronous clear of both event counters.
- `pll_rst` out 1: reset to the PLL, active high, registered.
- `rst_out` out NUM_STAGES: per-stage downstream resets, active high, registered. Bit 0 is released first.
- `ready` out 1: high when all stages are released and lock is held.
- `state_o` out 3: current FSM state encoding, for debug.
- `loss_count` out 8: lock losses after reaching RELEASE or RUN, saturating at 255.
- `timeout_count` out 8: lock timeouts, saturating at 255.

## Operation

- `pll_locked` passes through a 2-FF synchronizer to give `locked_s`. All decisions use `locked_s`.
- FSM states and encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4. Unused encodings go to PLL_RST.
- **PLL_RST:**
  - `pll_rst`=1 and all `rst_out`=1.
  - After PLL_RST_CYCLES clocks, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - `pll_rst`=0. A timer counts clocks.
  - If `locked_s`=1, go to STABLE.
  - If the timer reaches LOCK_TIMEOUT, go to PLL_RST and increment `timeout_count`.
  - If lock and timeout occur in the same clock, lock wins.
- **STABLE:**
  - Counts consecutive clocks with `locked_s`=1.
  - If `locked_s`=0, go to WAIT_LOCK. The WAIT_LOCK timer restarts and no counter increments.
  - When the count reaches LOCK_STABLE_CYCLES, go to RELEASE.
- **RELEASE:**
  - `rst_out[0]` falls on the edge that enters RELEASE.
  - `rst_out[i]` falls exactly STAGE_DELAY clocks after `rst_out[i-1]`.
  - After the last stage falls, go to RUN.
- **RUN:** `ready`=1.
- **Loss of lock in RELEASE or RUN:**
  - On the first clock with `locked_s`=0, the next edge sets all `rst_out`=1, `ready`=0 and state PLL_RST.
  - `loss_count` increments.
- **Counters:**
  - Both counters saturate at 255.
  - `clr_count` zeroes both. If a clear and an increment occur in the same clock, the clear wins and the result is 0.
- **`rst` asserted** (any state, including mid-RELEASE) applies reset values on the next edge:
  - state PLL_RST, `pll_rst`=1, `rst_out` all 1, `ready`=0, both counters 0;
  - internal timers 0 and synchronizer flops 0.

## Timing

- Reset values: `pll_rst`=1, `rst_out`=all 1, `ready`=0, `state_o`=0, `loss_count`=0, `timeout_count`=0.
- `pll_rst` stays high during `rst` and for exactly PLL_RST_CYCLES clocks after the first edge with `rst`=0.
- `pll_locked` to `locked_s` latency is 2 clocks. `locked_s` to FSM reaction is 1 clock.
- Best-case latency from the `pll_locked` rise to the `rst_out[0]` fall is 2 + 1 + LOCK_STABLE_CYCLES clocks.
- `ready` rises on the same edge as the last `rst_out` bit falls.
- Loss of lock response: 3 clocks from the `pll_locked` fall to `rst_out` all 1 and `ready`=0.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan

Bench parameters: PLL_RST_CYCLES=2, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=4, STAGE_DELAY=3, NUM_STAGES=2.

1. **Nominal bring-up.** Release `rst`, raise `pll_locked` at cycle 5.
   - `pll_rst` is high for cycles 1–2.
   - `rst_out[0]` falls 7 clocks after the `pll_locked` rise; `rst_out[1]` and `ready` change 3 clocks later.
2. **Lock timeout.** Hold `pll_locked`=0.
   - `pll_rst` re-pulses every 22 clocks.
   - `timeout_count` reads 3 after the third timeout.
3. **Glitch in STABLE.** Drop `pll_locked` for 1 clock mid-stability count.
   - FSM returns to WAIT_LOCK and then restarts the full 4-clock count.
   - No counter changes and `rst_out` stays all 1.
4. **Loss in RUN.** Drop `pll_locked`.
   - 3 clocks later `rst_out`=11, `ready`=0 and `loss_count`=1.
   - `pll_rst` pulses for 2 clocks, then normal re-lock proceeds.
5. **Loss mid-RELEASE and `rst` mid-RELEASE.**
   - Drop `pll_locked` after `rst_out[0]` falls: both bits re-assert and `loss_count` increments.
   - Separately, assert `rst` in RELEASE: all reset values are restored on the next edge.
6. **Counter saturation and clear.**
   - Force 256 timeouts: `timeout_count` holds at 255.
   - Assert `clr_count` in the same clock as a loss event: both counters read 0.
